// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 1- or 2-word instructions from a 1-cycle-latency
// synchronous memory and hands them to control over a valid/ready handshake.
module fetch_unit #(
   parameter int          ADDR_W   = 16,
   parameter int          DATA_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int          LONG_BIT = 15
) (
   input  logic              clk,
   input  logic              rst_async_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_word0,
   output logic [DATA_W-1:0] inst_word1,
   output logic              inst_long,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [2:0]        dbg_state
);

   // Handshake: inst_valid stays high with all inst_* outputs frozen until a
   // cycle with inst_ready=1 (transfer on that rising edge); valid never drops
   // without a transfer except on a jump, which also consumes the held instruction.

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH0 = 3'd1,
      S_WAIT0  = 3'd2,
      S_WAIT1  = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [ADDR_W-1:0] pc_inc1;
   logic              cap_word0;
   logic              cap_word1;
   logic              rdata_long;

   assign pc_inc1    = pc + ADDR_W'(1);
   assign rdata_long = mem_rdata[LONG_BIT];
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         state <= S_INIT;
         pc    <= RESET_PC_V;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      inst_valid = 1'b0;
      cap_word0  = 1'b0;
      cap_word1  = 1'b0;
      case (state)
         S_INIT: begin
            state_nxt = S_FETCH0;
         end
         S_FETCH0: begin
            mem_rd_en = 1'b1;
            mem_addr  = pc;
            state_nxt = S_WAIT0;
         end
         S_WAIT0: begin
            // Second word is requested in the same cycle word0 returns.
            cap_word0 = 1'b1;
            mem_addr  = pc_inc1;
            if (rdata_long) begin
               mem_rd_en = 1'b1;
               state_nxt = S_WAIT1;
            end else begin
               state_nxt = S_HOLD;
            end
         end
         S_WAIT1: begin
            cap_word1 = 1'b1;
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            inst_valid = 1'b1;
            if (inst_ready) begin
               pc_nxt    = pc + (inst_long ? ADDR_W'(2) : ADDR_W'(1));
               state_nxt = S_FETCH0;
            end
         end
         default: begin
            state_nxt = S_INIT;
         end
      endcase
      // A jump overrides everything, including a same-cycle handshake, and
      // drops whatever read is still in flight.
      if (jump_valid && (state != S_INIT)) begin
         pc_nxt    = jump_addr;
         state_nxt = S_FETCH0;
         cap_word0 = 1'b0;
         cap_word1 = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         inst_word0 <= '0;
         inst_word1 <= '0;
         inst_long  <= 1'b0;
         inst_pc    <= '0;
      end else begin
         if (cap_word0) begin
            inst_word0 <= mem_rdata;
            inst_pc    <= pc;
            inst_long  <= rdata_long;
            if (!rdata_long) begin
               inst_word1 <= '0;
            end
         end
         if (cap_word1) begin
            inst_word1 <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, read-address scoreboard and
// hand-computed instruction checks.
module tb_fetch_unit;

   logic        clk;
   logic        rst_async_n;
   logic [15:0] mem_addr;
   logic        mem_rd_en;
   logic [15:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst_word0;
   logic [15:0] inst_word1;
   logic        inst_long;
   logic [15:0] inst_pc;
   logic        jump_valid;
   logic [15:0] jump_addr;
   logic [2:0]  dbg_state;

   logic [15:0] mem [0:65535];
   logic [15:0] exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit #(
      .ADDR_W(16), .DATA_W(16), .RESET_PC(0), .LONG_BIT(15)
   ) dut (
      .clk(clk),
      .rst_async_n(rst_async_n),
      .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst_word0(inst_word0),
      .inst_word1(inst_word1),
      .inst_long(inst_long),
      .inst_pc(inst_pc),
      .jump_valid(jump_valid),
      .jump_addr(jump_addr),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous memory, 1-cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every read strobe must match the next expected address
   always @(negedge clk) begin
      if (rst_async_n && mem_rd_en) begin
         if (exp_q.size() == 0) check("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
         else check("rd_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_inst(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                             input logic lng, input logic [15:0] pc);
      check({tag, "_valid"}, 32'(inst_valid), 32'd1);
      check({tag, "_word0"}, 32'(inst_word0), 32'(w0));
      check({tag, "_word1"}, 32'(inst_word1), 32'(w1));
      check({tag, "_long"},  32'(inst_long),  32'(lng));
      check({tag, "_pc"},    32'(inst_pc),    32'(pc));
   endtask

   task automatic check_read(input string tag, input logic [15:0] addr);
      check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
      check({tag, "_addr"},  32'(mem_addr),  32'(addr));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0000] = 16'h1234;
      mem[16'h0001] = 16'h0007;
      mem[16'h0004] = 16'h8001;
      mem[16'h0005] = 16'hBEEF;
      mem[16'h0006] = 16'h8123;
      mem[16'h0007] = 16'h1111;
      mem[16'h0100] = 16'h0042;
      mem[16'h0020] = 16'h0003;
      mem[16'hFFFF] = 16'h8000;
      mem_rdata   = 16'h0000;
      rst_async_n = 1'b0;
      inst_ready  = 1'b0;
      jump_valid  = 1'b0;
      jump_addr   = 16'h0000;
      exp_q = '{16'h0000, 16'h0001, 16'h0004, 16'h0005, 16'h0006, 16'h0007,
                16'h0100, 16'h0020, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};

      // reset state
      tick(); tick();
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_word0", 32'(inst_word0), 32'd0);
      check("rst_pc",    32'(inst_pc),    32'd0);

      // first fetch after release
      rst_async_n = 1'b1;
      tick();
      check_read("first", 16'h0000);
      tick();
      check("first_lat_valid", 32'(inst_valid), 32'd0);
      tick();
      check_inst("first", 16'h1234, 16'h0000, 1'b0, 16'h0000);

      // backpressure: five held cycles, outputs frozen, no reads
      for (int i = 0; i < 5; i++) begin
         tick();
         check_inst("hold", 16'h1234, 16'h0000, 1'b0, 16'h0000);
         check("hold_rd_en", 32'(mem_rd_en), 32'd0);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check_read("after_hold", 16'h0001);
      tick();
      check("short_lat_valid", 32'(inst_valid), 32'd0);
      tick();
      check_inst("short1", 16'h0007, 16'h0000, 1'b0, 16'h0001);

      // jump to 4 from HOLD, then a long instruction
      jump_valid = 1'b1; jump_addr = 16'h0004;
      tick();
      jump_valid = 1'b0;
      check("jmp4_valid", 32'(inst_valid), 32'd0);
      check_read("long_w0", 16'h0004);
      tick();
      check_read("long_w1", 16'h0005);
      tick();
      check("long_lat_valid", 32'(inst_valid), 32'd0);
      tick();
      check_inst("long", 16'h8001, 16'hBEEF, 1'b1, 16'h0004);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check_read("after_long", 16'h0006);

      // jump while waiting on word1: partial instruction dropped
      tick();
      check_read("part_w1", 16'h0007);
      tick();
      check("part_wait1_valid", 32'(inst_valid), 32'd0);
      jump_valid = 1'b1; jump_addr = 16'h0100;
      tick();
      jump_valid = 1'b0;
      check("part_drop_valid", 32'(inst_valid), 32'd0);
      check_read("jmp100", 16'h0100);
      tick();
      check("jmp100_lat_valid", 32'(inst_valid), 32'd0);
      tick();
      check_inst("jmp100", 16'h0042, 16'h0000, 1'b0, 16'h0100);

      // jump and handshake together: jump wins
      jump_valid = 1'b1; jump_addr = 16'h0020; inst_ready = 1'b1;
      tick();
      jump_valid = 1'b0; inst_ready = 1'b0;
      check_read("jmp_prio", 16'h0020);
      check("jmp_prio_valid", 32'(inst_valid), 32'd0);
      tick(); tick();
      check_inst("jmp20", 16'h0003, 16'h0000, 1'b0, 16'h0020);

      // wrap-around long instruction at 0xFFFF
      mem[16'h0000] = 16'h5555;
      jump_valid = 1'b1; jump_addr = 16'hFFFF;
      tick();
      jump_valid = 1'b0;
      check_read("wrap_w0", 16'hFFFF);
      tick();
      check_read("wrap_w1", 16'h0000);
      tick(); tick();
      check_inst("wrap", 16'h8000, 16'h5555, 1'b1, 16'hFFFF);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check_read("after_wrap", 16'h0001);

      // asynchronous reset in the middle of S_WAIT0
      tick();
      #2;
      rst_async_n = 1'b0;
      #1;
      check("arst_rd_en", 32'(mem_rd_en), 32'd0);
      check("arst_addr",  32'(mem_addr),  32'd0);
      check("arst_valid", 32'(inst_valid), 32'd0);
      check("arst_word0", 32'(inst_word0), 32'd0);
      check("arst_word1", 32'(inst_word1), 32'd0);
      check("arst_long",  32'(inst_long),  32'd0);
      check("arst_pc",    32'(inst_pc),    32'd0);
      tick();
      rst_async_n = 1'b1;
      tick();
      check_read("refetch", 16'h0000);
      tick(); tick();
      check_inst("refetch", 16'h5555, 16'h0000, 1'b0, 16'h0000);

      tick();
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
